kpn_fifo_buffer: RTL and testbench
==================================

KPN_FIFO_BUFFER -- requirements
Module: kpn_fifo_buffer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  B  16  data word width in bits
  W  5  address bits; depth = 2**W words
  AF_THRESH  2**W-4  occupancy at or above which almost_full asserts
  DROP_ZERO  1  1 = all-zero write words are discarded silently
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high reset
  wr  in  1  write request
  entry_1  in  B  write data
  rd  in  1  read request
  clr_err  in  1  clears sticky error flags
  output_1  out  B  registered read data
  output_valid  out  1  output_1 carries a newly popped word
  full  out  1  occupancy == 2**W
  empty  out  1  occupancy == 0
  almost_full  out  1  occupancy >= AF_THRESH
  count  out  W+1  occupancy, 0..2**W
  overflow  out  1  sticky: write refused because full
  underflow  out  1  sticky: read refused because empty

Function
REQ-003 Write SHALL be accepted on a clk edge when wr=1, ~full (or full with read accepted same edge), and not (DROP_ZERO=1 and entry_1==0).
REQ-004 Accepted write SHALL store entry_1 at w_ptr and advance w_ptr by 1 modulo 2**W.
REQ-005 Read SHALL be accepted on a clk edge when rd=1 and ~empty.
REQ-006 Accepted read SHALL load output_1 with the word at r_ptr on that same edge, advance r_ptr modulo 2**W, and set output_valid=1 for exactly that following cycle.
REQ-007 output_1 SHALL hold its last value when no read is accepted; output_valid SHALL be 0 then.
REQ-008 wr=1 and rd=1 with 0 < count < 2**W SHALL perform both; count unchanged.
REQ-009 wr=1 and rd=1 while empty SHALL accept the write only; read refused, underflow set; the new word is not bypassed to output_1.
REQ-010 wr=1 and rd=1 while full SHALL perform both; read returns oldest word, write takes freed slot; full stays 1; overflow not set.
REQ-011 wr=1 while full without accepted read SHALL drop the word and set overflow.
REQ-012 Zero words dropped under DROP_ZERO SHALL not change any state and SHALL not set overflow.
REQ-013 count SHALL be +1 on write-only, -1 on read-only, unchanged otherwise; full, empty, almost_full SHALL be registered and consistent with count every cycle.
REQ-014 overflow/underflow SHALL stay set until clr_err=1 on an edge; a same-edge new error SHALL win over clr_err.
REQ-015 Written-then-read data SHALL emerge in FIFO order, bit-exact, across pointer wrap-around.

Reset
REQ-016 reset=1 SHALL immediately force: pointers 0, count 0, empty 1, full 0, almost_full 0, output_1 0, output_valid 0, overflow 0, underflow 0.
REQ-017 Storage array SHALL not be reset; contents are discarded by pointer reset.
REQ-018 Reset asserted mid-operation SHALL abort any in-flight read/write; first accepted operation after release uses address 0.

Structure
REQ-019 Shared package kpn_fifo_pkg SHALL hold default B, W, AF_THRESH and the DROP_ZERO encoding, reused by all KPN channel instances.
REQ-020 Storage SHALL be a sub-module kpn_fifo_ram (2**W x B, synchronous write, single write and single read port); control, pointers, flags stay in kpn_fifo_buffer.
REQ-021 Pointers SHALL be W bits; count W+1 bits; no combinational path from wr/rd to full/empty/count.

Verification
REQ-022 Bench SHALL cover:
  Reset, write 0x0001..0x0003, read 3 -> output_1 0x0001,0x0002,0x0003 each with output_valid pulse; empty=1, count=0.
  Write 32 words 0x0101.. (W=5) -> full=1, count=32, almost_full from count=28; 33rd write -> overflow=1, count=32.
  Full, wr+rd same edge with 0xBEEF -> output_1 oldest word, full stays 1, last read after 32 pops returns 0xBEEF.
  Empty, rd=1 -> underflow=1, output_valid=0; wr+rd with 0x00AA -> count=1, next rd returns 0x00AA.
  DROP_ZERO=1, write 0x0000 then 0x0005 -> count=1, overflow=0, read returns 0x0005.
  40 write/read pairs to force wrap, reset asserted mid-burst -> all outputs at reset values immediately, next write/read returns new data.

Source files
------------

// File: rtl/kpn_fifo_pkg.sv
// Defaults shared by every KPN channel FIFO instance.
package kpn_fifo_pkg;

    localparam int KPN_B = 16;
    localparam int KPN_W = 5;

    localparam bit KPN_KEEP_ZERO = 1'b0;
    localparam bit KPN_DROP_ZERO = 1'b1;

    function automatic int kpn_af_thresh(input int w);
        return (2 ** w) - 4;
    endfunction

    localparam int KPN_AF_THRESH = kpn_af_thresh(KPN_W);

endpackage

// File: rtl/kpn_fifo_ram.sv
// FIFO storage: 2**W x B, synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the controller decides when writes happen.
module kpn_fifo_ram #(
    parameter int B = 16,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [W-1:0] wr_addr,
    input  logic [B-1:0] wr_dat,
    input  logic [W-1:0] rd_addr,
    output logic [B-1:0] rd_dat
);

    logic [B-1:0] mem [2**W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // A same-edge write to rd_addr lands after the edge, so the read sees the old word.
    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/kpn_fifo_buffer.sv
// KPN channel FIFO with registered read data, registered flags and sticky errors.
// Latency: popped word appears on output_1 one edge after rd; flags follow their edge.
// Backpressure: writes refused while full unless a read frees a slot on the same edge.
module kpn_fifo_buffer
    import kpn_fifo_pkg::*;
#(
    parameter int B         = KPN_B,
    parameter int W         = KPN_W,
    parameter int AF_THRESH = kpn_af_thresh(W),
    parameter bit DROP_ZERO = KPN_DROP_ZERO
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] entry_1,
    input  logic         rd,
    input  logic         clr_err,
    output logic [B-1:0] output_1,
    output logic         output_valid,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam logic [W:0] DEPTH  = (W+1)'(2 ** W);
    localparam logic [W:0] AF_LVL = (W+1)'(AF_THRESH);

    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic [B-1:0] rd_word;
    logic         zero_drop;
    logic         rd_ok;
    logic         wr_ok;
    logic [W:0]   count_nxt;

    assign zero_drop = DROP_ZERO && (entry_1 == '0);
    assign rd_ok     = rd && !empty;
    assign wr_ok     = wr && !zero_drop && (!full || rd_ok);

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + (W+1)'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - (W+1)'(1);
        end
    end

    kpn_fifo_ram #(.B(B), .W(W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (w_ptr),
        .wr_dat  (entry_1),
        .rd_addr (r_ptr),
        .rd_dat  (rd_word)
    );

    // Flags are computed from next-state count so they stay registered yet exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            output_1     <= '0;
            output_valid <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + W'(1);
            end
            if (rd_ok) begin
                r_ptr    <= r_ptr + W'(1);
                output_1 <= rd_word;
            end
            output_valid <= rd_ok;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_LVL);
            if (wr && !zero_drop && full && !rd_ok) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kpn_fifo_buffer.sv
// Bench for kpn_fifo_buffer: directed table, directed sequences, random traffic vs a queue model.
module tb_kpn_fifo_buffer;
    import kpn_fifo_pkg::*;

    localparam int B     = KPN_B;
    localparam int W     = KPN_W;
    localparam int DEPTH = 2 ** W;
    localparam int AF    = DEPTH - 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr;
    logic         rd;
    logic         clr_err;
    logic [B-1:0] entry_1;
    logic [B-1:0] output_1;
    logic         output_valid;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic [W:0]   count;
    logic         overflow;
    logic         underflow;

    kpn_fifo_buffer #(.B(B), .W(W), .AF_THRESH(AF), .DROP_ZERO(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .entry_1      (entry_1),
        .rd           (rd),
        .clr_err      (clr_err),
        .output_1     (output_1),
        .output_valid (output_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a plain queue of stored words plus the observable registers.
    logic [B-1:0] q[$];
    logic [B-1:0] m_out;
    logic         m_vld;
    logic         m_ovf;
    logic         m_unf;

    typedef struct {
        logic         w;
        logic [B-1:0] d;
        logic         r;
        logic         c;
        logic [B-1:0] e_out;
        logic         e_vld;
        int           e_cnt;
        logic         e_ovf;
        logic         e_unf;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic w, input logic [B-1:0] d, input logic r, input logic c,
                                input logic [B-1:0] e_out, input logic e_vld, input int e_cnt,
                                input logic e_ovf, input logic e_unf);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.c = c;
        v.e_out = e_out; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic w, input logic [B-1:0] d, input logic r, input logic c);
        bit zero, is_full, rd_acc, wr_acc;
        zero    = (d == '0);
        is_full = (q.size() == DEPTH);
        rd_acc  = r && (q.size() != 0);
        wr_acc  = w && !zero && (!is_full || rd_acc);
        m_vld   = rd_acc;
        if (rd_acc) m_out = q.pop_front();
        if (wr_acc) q.push_back(d);
        if (w && !zero && is_full && !rd_acc) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (r && !rd_acc) m_unf = 1'b1;
        else if (c) m_unf = 1'b0;
    endtask

    task automatic drive(input logic w, input logic [B-1:0] d, input logic r, input logic c);
        @(negedge clk);
        wr = w; entry_1 = d; rd = r; clr_err = c;
        model_step(w, d, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/out"},   output_1,     m_out);
        chk({tag, "/vld"},   output_valid, m_vld);
        chk({tag, "/cnt"},   count,        q.size());
        chk({tag, "/full"},  full,         q.size() == DEPTH);
        chk({tag, "/empty"}, empty,        q.size() == 0);
        chk({tag, "/af"},    almost_full,  q.size() >= AF);
        chk({tag, "/ovf"},   overflow,     m_ovf);
        chk({tag, "/unf"},   underflow,    m_unf);
    endtask

    task automatic step(input string tag, input logic w, input logic [B-1:0] d, input logic r, input logic c);
        drive(w, d, r, c);
        check_model(tag);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "/out"},   output_1,     0);
        chk({tag, "/vld"},   output_valid, 0);
        chk({tag, "/cnt"},   count,        0);
        chk({tag, "/full"},  full,         0);
        chk({tag, "/empty"}, empty,        1);
        chk({tag, "/af"},    almost_full,  0);
        chk({tag, "/ovf"},   overflow,     0);
        chk({tag, "/unf"},   underflow,    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; entry_1 = '0;
        m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        check_reset("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        //            w  d         r  c  out       vld cnt ovf unf
        tbl[0]  = mk(1, 16'h0001, 0, 0, 16'h0000, 0, 1, 0, 0);
        tbl[1]  = mk(1, 16'h0002, 0, 0, 16'h0000, 0, 2, 0, 0);
        tbl[2]  = mk(1, 16'h0003, 0, 0, 16'h0000, 0, 3, 0, 0);
        tbl[3]  = mk(0, 16'h0000, 1, 0, 16'h0001, 1, 2, 0, 0);
        tbl[4]  = mk(0, 16'h0000, 1, 0, 16'h0002, 1, 1, 0, 0);
        tbl[5]  = mk(0, 16'h0000, 1, 0, 16'h0003, 1, 0, 0, 0);
        tbl[6]  = mk(0, 16'h0000, 0, 0, 16'h0003, 0, 0, 0, 0);
        tbl[7]  = mk(0, 16'h0000, 1, 0, 16'h0003, 0, 0, 0, 1);
        tbl[8]  = mk(1, 16'h00AA, 1, 0, 16'h0003, 0, 1, 0, 1);
        tbl[9]  = mk(0, 16'h0000, 1, 0, 16'h00AA, 1, 0, 0, 1);
        tbl[10] = mk(0, 16'h0000, 0, 1, 16'h00AA, 0, 0, 0, 0);
        tbl[11] = mk(1, 16'h0000, 0, 0, 16'h00AA, 0, 0, 0, 0);
        tbl[12] = mk(1, 16'h0005, 0, 0, 16'h00AA, 0, 1, 0, 0);
        tbl[13] = mk(0, 16'h0000, 1, 0, 16'h0005, 1, 0, 0, 0);
        tbl[14] = mk(0, 16'h0000, 1, 1, 16'h0005, 0, 0, 0, 1);
        tbl[15] = mk(0, 16'h0000, 0, 1, 16'h0005, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
            chk($sformatf("vec%0d/out", i),   output_1,     tbl[i].e_out);
            chk($sformatf("vec%0d/vld", i),   output_valid, tbl[i].e_vld);
            chk($sformatf("vec%0d/cnt", i),   count,        tbl[i].e_cnt);
            chk($sformatf("vec%0d/empty", i), empty,        tbl[i].e_cnt == 0);
            chk($sformatf("vec%0d/full", i),  full,         tbl[i].e_cnt == DEPTH);
            chk($sformatf("vec%0d/ovf", i),   overflow,     tbl[i].e_ovf);
            chk($sformatf("vec%0d/unf", i),   underflow,    tbl[i].e_unf);
        end

        // Fill to full, then overflow, then simultaneous read/write while full.
        for (int i = 0; i < DEPTH; i++) begin
            step("fill", 1'b1, B'(16'h0101 + i), 1'b0, 1'b0);
            chk("fill/af_at", almost_full, (i + 1) >= 28);
        end
        chk("full_flag", full, 1);
        chk("full_cnt", count, 32);
        step("wr33", 1'b1, 16'h0200, 1'b0, 1'b0);
        chk("wr33/ovf", overflow, 1);
        chk("wr33/cnt", count, 32);
        step("clr_ovf", 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("clr_ovf/ovf", overflow, 0);
        step("full_wr_rd", 1'b1, 16'hBEEF, 1'b1, 1'b0);
        chk("full_wr_rd/out", output_1, 16'h0101);
        chk("full_wr_rd/full", full, 1);
        chk("full_wr_rd/ovf", overflow, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        chk("drain/last", output_1, 16'hBEEF);
        chk("drain/empty", empty, 1);

        // Random traffic, alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 400; i++) begin
            logic w, r, c;
            logic [B-1:0] d;
            bit fillish;
            fillish = ((i / 50) % 2) == 0;
            w = $urandom_range(99, 0) < (fillish ? 75 : 30);
            r = $urandom_range(99, 0) < (fillish ? 30 : 75);
            c = $urandom_range(15, 0) == 0;
            d = ($urandom_range(7, 0) == 0) ? '0 : B'($urandom);
            step("rand", w, d, r, c);
        end

        // Write/read pairs to wrap the pointers, then reset mid-burst.
        for (int i = 0; i < 40; i++) begin
            step("pair_wr", 1'b1, B'(16'h3000 + i), 1'b0, 1'b0);
            step("pair_rd", 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        step("pre_rst", 1'b1, 16'h4444, 1'b0, 1'b0);
        step("pre_rst", 1'b1, 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        wr = 1'b1; entry_1 = 16'h6666; rd = 1'b1; clr_err = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset("mid_rst");
        @(posedge clk);
        #1;
        check_reset("rst_hold");
        @(negedge clk);
        reset = 1'b0; wr = 1'b0; rd = 1'b0;
        q.delete();
        m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        step("post_wr", 1'b1, 16'h7777, 1'b0, 1'b0);
        step("post_rd", 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("post_rst/out", output_1, 16'h7777);
        chk("post_rst/vld", output_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
